// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci controller, its ALU and the top level:
// controller state encoding and the ALU opcode set.
package fib_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ADD   = 3'd2,
        ST_DEC   = 3'd3,
        ST_DONE  = 3'd4
    } fib_state_t;

    localparam int DATA_W = 4;

    localparam logic [2:0] ALU_OP_ADD = 3'b000;
    localparam logic [2:0] ALU_OP_SUB = 3'b001;
    localparam logic [2:0] ALU_OP_AND = 3'b010;
    localparam logic [2:0] ALU_OP_OR  = 3'b011;
    localparam logic [2:0] ALU_OP_XOR = 3'b100;
    localparam logic [2:0] ALU_OP_PASS_A = 3'b101;

endpackage

// File: rtl/fib_alu.sv
// Shared 4-bit combinational ALU; results wrap modulo 16.
module fib_alu
    import fib_pkg::*;
(
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] o,
    output logic              zero
);

    // Operation select; unused opcodes produce zero.
    always_comb begin
        o = '0;
        case (opcode)
            ALU_OP_ADD:    o = a + b;
            ALU_OP_SUB:    o = a - b;
            ALU_OP_AND:    o = a & b;
            ALU_OP_OR:     o = a | b;
            ALU_OP_XOR:    o = a ^ b;
            ALU_OP_PASS_A: o = a;
            default:       o = '0;
        endcase
    end

    assign zero = (o == '0);

endmodule

// File: rtl/fib_top.sv
// Top level: Fibonacci controller wired to the shared ALU.
module fib_top
    import fib_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    logic [2:0]        alu_opcode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_o;
    logic              alu_zero;

    fib_ctrl #(
        .OP_ADD (ALU_OP_ADD),
        .OP_SUB (ALU_OP_SUB)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n          (n),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_o      (alu_o),
        .alu_zero   (alu_zero),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .overflow   (overflow)
    );

    fib_alu u_alu (
        .opcode (alu_opcode),
        .a      (alu_a),
        .b      (alu_b),
        .o      (alu_o),
        .zero   (alu_zero)
    );

endmodule

// File: rtl/fib_ctrl.sv
// Fibonacci sequencer: computes F(n) mod 16 by iterating prev/curr through
// an external ALU, with a sticky overflow flag tracked per term.
module fib_ctrl
    import fib_pkg::*;
#(
    parameter logic [2:0] OP_ADD = ALU_OP_ADD,
    parameter logic [2:0] OP_SUB = ALU_OP_SUB
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] n,
    output logic [2:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_o,
    input  logic              alu_zero,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    fib_state_t        state_reg, state_next;
    logic [DATA_W-1:0] prev_reg, prev_next;
    logic [DATA_W-1:0] curr_reg, curr_next;
    logic [DATA_W-1:0] cnt_reg, cnt_next;
    logic              prev_ovf_reg, prev_ovf_next;
    logic              curr_ovf_reg, curr_ovf_next;
    logic [DATA_W-1:0] result_reg, result_next;
    logic              overflow_reg, overflow_next;
    logic              busy_reg, busy_next;

    // State and datapath registers; reset clears everything, aborting any run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            prev_reg     <= '0;
            curr_reg     <= '0;
            cnt_reg      <= '0;
            prev_ovf_reg <= 1'b0;
            curr_ovf_reg <= 1'b0;
            result_reg   <= '0;
            overflow_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            prev_reg     <= prev_next;
            curr_reg     <= curr_next;
            cnt_reg      <= cnt_next;
            prev_ovf_reg <= prev_ovf_next;
            curr_ovf_reg <= curr_ovf_next;
            result_reg   <= result_next;
            overflow_reg <= overflow_next;
            busy_reg     <= busy_next;
        end
    end

    // Next-state logic, datapath updates and state-decoded ALU/done outputs.
    always_comb begin
        state_next    = state_reg;
        prev_next     = prev_reg;
        curr_next     = curr_reg;
        cnt_next      = cnt_reg;
        prev_ovf_next = prev_ovf_reg;
        curr_ovf_next = curr_ovf_reg;
        result_next   = result_reg;
        overflow_next = overflow_reg;
        alu_opcode    = OP_ADD;
        alu_a         = '0;
        alu_b         = '0;
        done          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    prev_next     = '0;
                    curr_next     = 4'd1;
                    cnt_next      = n;
                    prev_ovf_next = 1'b0;
                    curr_ovf_next = 1'b0;
                    state_next    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // cnt - 0 lets the ALU zero flag act as the loop terminator.
                alu_opcode = OP_SUB;
                alu_a      = cnt_reg;
                alu_b      = '0;
                if (alu_zero) begin
                    result_next   = prev_reg;
                    overflow_next = prev_ovf_reg;
                    state_next    = ST_DONE;
                end else begin
                    state_next = ST_ADD;
                end
            end
            ST_ADD: begin
                // A wrapped sum is smaller than either operand.
                alu_opcode    = OP_ADD;
                alu_a         = prev_reg;
                alu_b         = curr_reg;
                prev_next     = curr_reg;
                prev_ovf_next = curr_ovf_reg;
                curr_next     = alu_o;
                curr_ovf_next = curr_ovf_reg | (alu_o < prev_reg);
                state_next    = ST_DEC;
            end
            ST_DEC: begin
                alu_opcode = OP_SUB;
                alu_a      = cnt_reg;
                alu_b      = 4'd1;
                cnt_next   = alu_o;
                state_next = ST_CHECK;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    assign busy     = busy_reg;
    assign result   = result_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_fib_ctrl.sv
// Scoreboard bench for fib_ctrl driving a real fib_alu, with fib_top run in
// parallel on the same stimulus.
module tb_fib_ctrl;
    import fib_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] n;
    logic [2:0] alu_opcode;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_o;
    logic       alu_zero;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       overflow;
    logic       top_busy;
    logic       top_done;
    logic [3:0] top_result;
    logic       top_overflow;

    always #5 clk = ~clk;

    fib_ctrl #(
        .OP_ADD (ALU_OP_ADD),
        .OP_SUB (ALU_OP_SUB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n          (n),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_o      (alu_o),
        .alu_zero   (alu_zero),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .overflow   (overflow)
    );

    fib_alu u_alu (
        .opcode (alu_opcode),
        .a      (alu_a),
        .b      (alu_b),
        .o      (alu_o),
        .zero   (alu_zero)
    );

    fib_top u_top (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .n        (n),
        .busy     (top_busy),
        .done     (top_done),
        .result   (top_result),
        .overflow (top_overflow)
    );

    typedef struct {
        int res;
        int ovf;
        int lat;
        int c0;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc_cnt = 0;
    bit   run_active = 1'b0;
    int   run_n = 0;
    int   run_c0 = 0;
    bit   done_prev = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic int fib16(input int i);
        int fa = 0;
        int fb = 1;
        int t;
        for (int k = 0; k < i; k++) begin
            t  = (fa + fb) % 16;
            fa = fb;
            fb = t;
        end
        return fa;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc_cnt);
        end
    endtask

    // Monitor: per-cycle ALU drive check against a state-sequence model, and
    // scoreboard pop/compare whenever done is presented.
    always @(negedge clk) begin
        int k;
        int e_op;
        int e_a;
        int e_b;
        exp_t e;
        if (rst_n === 1'b1) begin
            chk("done_twice", int'(done && done_prev), 0);
            e_op = int'(ALU_OP_ADD);
            e_a  = 0;
            e_b  = 0;
            if (run_active) begin
                k = cyc_cnt - run_c0;
                if (k == 3 * run_n + 1) begin
                    e_op = int'(ALU_OP_ADD);
                end else if (k % 3 == 0) begin
                    e_op = int'(ALU_OP_SUB);
                    e_a  = run_n - k / 3;
                    e_b  = 0;
                end else if (k % 3 == 1) begin
                    e_op = int'(ALU_OP_ADD);
                    e_a  = fib16(k / 3);
                    e_b  = fib16(k / 3 + 1);
                end else begin
                    e_op = int'(ALU_OP_SUB);
                    e_a  = run_n - k / 3;
                    e_b  = 1;
                end
            end
            chk("alu_opcode", int'(alu_opcode), e_op);
            chk("alu_a", int'(alu_a), e_a);
            chk("alu_b", int'(alu_b), e_b);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", int'(result), e.res);
                    chk("overflow", int'(overflow), e.ovf);
                    chk("latency", cyc_cnt - e.c0 + 1, e.lat);
                    chk("top_done", int'(top_done), 1);
                    chk("top_result", int'(top_result), e.res);
                    chk("top_overflow", int'(top_overflow), e.ovf);
                    $display("done: result=%0d overflow=%0d latency=%0d (want %0d/%0d/%0d)",
                             result, overflow, cyc_cnt - e.c0 + 1, e.res, e.ovf, e.lat);
                end
                run_active = 1'b0;
            end
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (!busy && !run_active) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    // Issue one request and register its expected response.
    task automatic launch(input int nn, input bit push, input int er, input int eo);
        wait_idle();
        start = 1'b1;
        n     = 4'(nn);
        @(posedge clk);
        #1;
        run_active = 1'b1;
        run_n      = nn;
        run_c0     = cyc_cnt;
        if (push) exp_q.push_back('{er, eo, 3 * nn + 2, cyc_cnt});
    endtask

    task automatic run(input int nn, input int er, input int eo);
        launch(nn, 1'b1, er, eo);
        start = 1'b0;
    endtask

    // Directed stimulus.
    initial begin
        bit ok;
        rst_n = 1'b0;
        start = 1'b0;
        n     = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_overflow", int'(overflow), 0);
        rst_n = 1'b1;

        run(0, 0, 0);
        run(1, 1, 0);
        run(7, 13, 0);
        run(8, 5, 1);
        run(15, 2, 1);

        // start held through the whole run, n changed mid-run, still high in DONE
        launch(5, 1'b1, 5, 0);
        repeat (2) @(negedge clk);
        n = 4'd3;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (!run_active) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("held_timeout", 0, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        #1;
        chk("held_busy_after_done", int'(busy), 0);

        run(5, 5, 0);
        run(3, 2, 0);

        // reset during ADD of an n=6 run
        launch(6, 1'b0, 0, 0);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (busy && alu_opcode == ALU_OP_ADD) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("add_timeout", 0, 1);
        rst_n = 1'b0;
        run_active = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_overflow", int'(overflow), 0);
        chk("abort_alu_a", int'(alu_a), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        run(6, 8, 0);

        wait_idle();
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
